traffic_light_monitor: RTL and testbench
========================================

Name: traffic_light_monitor

Overview:
- Receiving end of the two-direction lamp interface (x1,v1,d1,x2,v2,d2; X=green, V=yellow, D=red).
- Decodes the six lamp lines into a phase, tracks how long each phase lasts, and checks sequence and timing against the configured durations.
- Produces per-direction countdown values for the CountLCD display path.
- Flags illegal lamp combinations and latches the first fault for the supervisor.

Parameters:
T_GREEN, 16, ticks each green phase lasts (valid range 2..200)
T_YELLOW, 6, ticks each yellow phase lasts (valid range 2..50)
CW, 8, width of dwell counter and countdown outputs

Ports:
clk  in  1  system clock
rs  in  1  synchronous active-high reset
tick  in  1  time-base strobe; dwell advances only on cycles where tick=1
x1  in  1  direction-1 green lamp
v1  in  1  direction-1 yellow lamp
d1  in  1  direction-1 red lamp
x2  in  1  direction-2 green lamp
v2  in  1  direction-2 yellow lamp
d2  in  1  direction-2 red lamp
clr_fault  in  1  clears the latched fault and returns the block to SYNC
phase  out  2  decoded phase: 0=G1R2, 1=Y1R2, 2=R1G2, 3=R1Y2
phase_valid  out  1  1 while in TRACK
remain1  out  CW  ticks left before the direction-1 lamp changes
remain2  out  CW  ticks left before the direction-2 lamp changes
fault  out  1  sticky fault flag
fault_code  out  3  first fault seen: 0 none, 1 illegal combo, 2 bad sequence, 3 dwell short, 4 dwell long

Behaviour:
- Clocking and reset:
  - Single clock domain; no synchronizers needed because the lamps are same-clock.
  - Reset is synchronous and active-high. All state is sampled on the clk edge where rs=1.
- Input stage:
  - The six lamp inputs are registered once. All decode uses the registered copy, so outputs lag the lamps by 1 cycle.
- Decode (one-hot compare of the 6-bit vector):
  - 100001 -> P0
  - 010001 -> P1
  - 001100 -> P2
  - 001010 -> P3
  - Any other value is illegal.
- Monitor FSM (states SYNC, TRACK, FAULT):
  - SYNC:
    - Entered on reset and on clr_fault.
    - phase_valid=0; remain1=0 and remain2=0.
    - Waits for the first change of decoded legal phase, then moves to TRACK with the new phase and dwell=0.
  - TRACK:
    - On each tick, dwell increments and saturates at 2^CW-1.
    - Legal successors: P0->P1->P2->P3->P0.
    - On a phase change, dwell is checked first:
      - dwell < expected-1 -> code 3 (dwell short).
      - Otherwise, the successor is checked; a wrong successor -> code 2 (bad sequence).
      - If both pass, dwell resets to 0 and the new phase is adopted.
    - Expected dwell: T_GREEN in P0 and P2; T_YELLOW in P1 and P3.
    - If, while the phase is unchanged, dwell reaches expected+1 on a tick -> code 4 (dwell long).
  - FAULT:
    - fault=1; fault_code holds the first code seen; phase_valid=0; remain outputs frozen.
    - Later faults do not overwrite fault_code.
    - Leaves FAULT only via clr_fault or rs.
- Illegal combination:
  - In any state, an illegal lamp vector sets code 1 and enters FAULT.
  - This has priority over codes 2, 3 and 4 in the same cycle.
- Simultaneous events:
  - clr_fault in the same cycle as a newly detected fault: the fault wins. Block ends in FAULT with the new code.
  - rs has priority over everything.
- Countdown, computed combinationally from registered phase and dwell, in TRACK only:
  - P0: remain1 = T_GREEN-1-dwell; remain2 = T_GREEN+T_YELLOW-1-dwell
  - P1: remain1 = T_YELLOW-1-dwell; remain2 = T_YELLOW-1-dwell
  - P2: remain1 = T_GREEN+T_YELLOW-1-dwell; remain2 = T_GREEN-1-dwell
  - P3: remain1 = T_YELLOW-1-dwell; remain2 = T_YELLOW-1-dwell
  - All results saturate at 0 and never wrap.
- Reset values: phase=0, phase_valid=0, remain1=0, remain2=0, fault=0, fault_code=0, FSM=SYNC, dwell=0, lamp register=000000.
- A fault or reset in the middle of a phase discards dwell with no partial checks.

Decomposition:
- Shared package tl_pkg holds:
  - the phase encodings P0..P3;
  - the fault code constants;
  - the 6-bit lamp patterns for each phase;
  - the monitor state encodings.
- One natural sub-module, tl_phase_decode: a combinational lamp-vector to {phase, legal} decoder, reusable by any other lamp consumer.
- Dwell counter, checker and countdown stay in the top module.

Test Plan:
- Nominal run (tick=1, defaults):
  - Stimulus: lamps cycle P0 16 clocks, P1 6, P2 16, P3 6, repeated twice.
  - First P0->P1 edge moves SYNC->TRACK; afterwards fault stays 0.
  - In P2, remain1 counts 21..0 and remain2 counts 15..0.
- Illegal combo:
  - Stimulus: drive 100100 (both green) for 1 cycle mid-P0.
  - Two cycles later fault=1, fault_code=1, phase_valid=0.
- Bad sequence:
  - Stimulus: jump P0->P2 after exactly 16 ticks.
  - fault_code=2.
- Dwell short and long:
  - P1 lasting 3 ticks -> fault_code=3.
  - Separately, P0 held 18 ticks -> fault_code=4 on the 18th tick, before any change.
- Tick gating:
  - Stimulus: tick=1 every 4th cycle, lamps stretched 4x.
  - No fault; remain values decrement once per tick.
- Clear and priority:
  - In FAULT, pulse clr_fault alone -> SYNC, fault=0, fault_code=0.
  - Repeat with an illegal combo in the same cycle -> remains FAULT, fault_code=1.
  - Assert rs mid-P2 -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/tl_pkg.sv
// tl_pkg: shared phase, lamp-pattern, fault-code and monitor-state definitions
package tl_pkg;

    // Decoded phase encodings
    localparam logic [1:0] P0 = 2'd0;
    localparam logic [1:0] P1 = 2'd1;
    localparam logic [1:0] P2 = 2'd2;
    localparam logic [1:0] P3 = 2'd3;

    // Lamp vector order is {x1, v1, d1, x2, v2, d2}
    localparam logic [5:0] LAMP_P0 = 6'b100001;
    localparam logic [5:0] LAMP_P1 = 6'b010001;
    localparam logic [5:0] LAMP_P2 = 6'b001100;
    localparam logic [5:0] LAMP_P3 = 6'b001010;

    // Fault codes; only the first one seen is latched
    localparam logic [2:0] FC_NONE    = 3'd0;
    localparam logic [2:0] FC_ILLEGAL = 3'd1;
    localparam logic [2:0] FC_SEQ     = 3'd2;
    localparam logic [2:0] FC_SHORT   = 3'd3;
    localparam logic [2:0] FC_LONG    = 3'd4;

    typedef enum logic [1:0] {S_SYNC, S_TRACK, S_FAULT} state_t;

endpackage

// File: rtl/traffic_light_monitor_if.sv
// traffic_light_monitor_if: lamp lines in, decoded phase, countdown and fault status out
interface traffic_light_monitor_if #(
    parameter int CW = 8
);
    logic          tick;
    logic          x1;
    logic          v1;
    logic          d1;
    logic          x2;
    logic          v2;
    logic          d2;
    logic          clr_fault;
    logic [1:0]    phase;
    logic          phase_valid;
    logic [CW-1:0] remain1;
    logic [CW-1:0] remain2;
    logic          fault;
    logic [2:0]    fault_code;

    modport master (
        output tick, x1, v1, d1, x2, v2, d2, clr_fault,
        input  phase, phase_valid, remain1, remain2, fault, fault_code
    );

    modport slave (
        input  tick, x1, v1, d1, x2, v2, d2, clr_fault,
        output phase, phase_valid, remain1, remain2, fault, fault_code
    );
endinterface

// File: rtl/tl_phase_decode.sv
// tl_phase_decode: maps a 6-bit lamp vector onto a phase and a legal flag
module tl_phase_decode
    import tl_pkg::*;
(
    input  logic [5:0] i_lamp,
    output logic [1:0] o_phase,
    output logic       o_legal
);
    // Exact pattern compare; anything not matching one of the four phases is illegal
    always_comb begin
        o_phase = (i_lamp == LAMP_P1) ? P1 : (i_lamp == LAMP_P2) ? P2 : (i_lamp == LAMP_P3) ? P3 : P0;
        o_legal = (i_lamp == LAMP_P0) || (i_lamp == LAMP_P1) || (i_lamp == LAMP_P2) || (i_lamp == LAMP_P3);
    end
endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: checks lamp sequence and phase timing, drives per-direction countdowns
module traffic_light_monitor
    import tl_pkg::*;
#(
    parameter int T_GREEN  = 16,
    parameter int T_YELLOW = 6,
    parameter int CW       = 8
) (
    input  logic                   clk,
    input  logic                   rs,
    traffic_light_monitor_if.slave bus
);
    localparam logic [CW-1:0] EXP_G = CW'(T_GREEN);
    localparam logic [CW-1:0] EXP_Y = CW'(T_YELLOW);
    localparam logic [CW-1:0] B_G   = CW'(T_GREEN - 1);
    localparam logic [CW-1:0] B_Y   = CW'(T_YELLOW - 1);
    localparam logic [CW-1:0] B_GY  = CW'(T_GREEN + T_YELLOW - 1);

    state_t        r_state;
    logic [5:0]    r_lamp;
    logic          r_lamp_vld;
    logic          r_seen;
    logic          r_cnt_en;
    logic          r_valid;
    logic          r_fault;
    logic [1:0]    r_phase;
    logic [2:0]    r_code;
    logic [CW-1:0] r_dwell;

    logic [1:0]    w_phase;
    logic          w_legal;
    logic          w_illegal;
    logic          w_change;
    logic [CW-1:0] w_exp;
    logic [CW-1:0] w_b1;
    logic [CW-1:0] w_b2;
    logic [2:0]    w_trk_code;
    logic [2:0]    w_new_code;

    tl_phase_decode u_dec (
        .i_lamp  (r_lamp),
        .o_phase (w_phase),
        .o_legal (w_legal)
    );

    // Fault detection: dwell is judged before successor on a change; illegal lamps outrank both
    always_comb begin
        w_illegal  = r_lamp_vld && !w_legal;
        w_change   = w_phase != r_phase;
        w_exp      = r_phase[0] ? EXP_Y : EXP_G;
        w_trk_code = !w_change ? ((bus.tick && r_dwell == w_exp) ? FC_LONG : FC_NONE)
                   : (r_dwell < w_exp - CW'(1)) ? FC_SHORT
                   : (w_phase != r_phase + 2'd1) ? FC_SEQ : FC_NONE;
        w_new_code = w_illegal ? FC_ILLEGAL : (r_state == S_TRACK) ? w_trk_code : FC_NONE;
        w_b1       = (r_phase == P0) ? B_G : (r_phase == P2) ? B_GY : B_Y;
        w_b2       = (r_phase == P0) ? B_GY : (r_phase == P2) ? B_G : B_Y;
    end

    assign bus.phase       = r_phase;
    assign bus.phase_valid = r_valid;
    assign bus.fault       = r_fault;
    assign bus.fault_code  = r_code;
    assign bus.remain1     = (r_cnt_en && w_b1 > r_dwell) ? w_b1 - r_dwell : '0;
    assign bus.remain2     = (r_cnt_en && w_b2 > r_dwell) ? w_b2 - r_dwell : '0;

    // Monitor FSM: a new fault beats clr_fault; in FAULT phase/dwell stay frozen so the countdown holds
    always_ff @(posedge clk) begin
        if (rs) begin
            r_state    <= S_SYNC;
            r_lamp     <= '0;
            r_lamp_vld <= 1'b0;
            r_seen     <= 1'b0;
            r_cnt_en   <= 1'b0;
            r_valid    <= 1'b0;
            r_fault    <= 1'b0;
            r_phase    <= P0;
            r_code     <= FC_NONE;
            r_dwell    <= '0;
        end else begin
            r_lamp     <= {bus.x1, bus.v1, bus.d1, bus.x2, bus.v2, bus.d2};
            r_lamp_vld <= 1'b1;
            if (w_new_code != FC_NONE && (r_state != S_FAULT || bus.clr_fault)) begin
                r_state <= S_FAULT;
                r_code  <= w_new_code;
                r_fault <= 1'b1;
                r_valid <= 1'b0;
            end else if (bus.clr_fault) begin
                r_state  <= S_SYNC;
                r_code   <= FC_NONE;
                r_fault  <= 1'b0;
                r_valid  <= 1'b0;
                r_seen   <= 1'b0;
                r_cnt_en <= 1'b0;
                r_dwell  <= '0;
            end else if (r_state == S_SYNC) begin
                if (w_legal) begin
                    r_phase <= w_phase;
                    r_seen  <= 1'b1;
                    if (r_seen && w_change) begin
                        r_state  <= S_TRACK;
                        r_valid  <= 1'b1;
                        r_cnt_en <= 1'b1;
                        r_dwell  <= '0;
                    end
                end
            end else if (r_state == S_TRACK) begin
                if (w_change) begin
                    r_phase <= w_phase;
                    r_dwell <= '0;
                end else if (bus.tick) begin
                    r_dwell <= r_dwell + CW'(r_dwell != '1);
                end
            end
        end
    end
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: scoreboard bench with a phase-level reference model
module tb_traffic_light_monitor;
    localparam int TG = 16;
    localparam int TY = 6;
    localparam int M_SYNC = 0;
    localparam int M_TRACK = 1;
    localparam int M_FAULT = 2;

    typedef struct {
        logic [1:0] ph;
        logic       pv;
        logic [7:0] r1;
        logic [7:0] r2;
        logic       f;
        logic [2:0] c;
    } exp_t;

    logic clk;
    logic rs;
    traffic_light_monitor_if #(.CW(8)) bus ();

    traffic_light_monitor #(.T_GREEN(TG), .T_YELLOW(TY), .CW(8)) dut (
        .clk (clk),
        .rs  (rs),
        .bus (bus)
    );

    exp_t       q[$];
    int         n_chk = 0;
    int         n_pass = 0;
    int         tc = 0;
    logic [5:0] pat [4];

    int         m_mode, m_ph, m_el, m_code;
    bit         m_seen, m_lv, m_cnt;
    logic [5:0] m_lamp;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic int dec(input logic [5:0] v);
        for (int p = 0; p < 4; p++) if (v == pat[p]) return p;
        return -1;
    endfunction

    // Reference model: acts on the lamp vector seen one cycle earlier
    function automatic void step(input logic [5:0] lamps, input bit tk, input bit clr, input bit r);
        int p, nc, durs;
        if (r) begin
            m_mode = M_SYNC; m_ph = 0; m_el = 0; m_code = 0;
            m_seen = 0; m_lv = 0; m_cnt = 0; m_lamp = 6'b0;
            return;
        end
        p = m_lv ? dec(m_lamp) : -2;
        nc = 0;
        durs = (m_ph % 2 == 1) ? TY : TG;
        if (p == -1) nc = 1;
        else if (m_mode == M_TRACK && p >= 0) begin
            if (p != m_ph) nc = (m_el < durs - 1) ? 3 : (p != (m_ph + 1) % 4) ? 2 : 0;
            else if (tk && m_el + 1 > durs) nc = 4;
        end
        if (nc != 0 && (m_mode != M_FAULT || clr)) begin
            m_mode = M_FAULT; m_code = nc;
        end else if (clr) begin
            m_mode = M_SYNC; m_code = 0; m_seen = 0; m_cnt = 0; m_el = 0;
        end else if (m_mode == M_SYNC && p >= 0) begin
            if (m_seen && p != m_ph) begin
                m_mode = M_TRACK; m_cnt = 1; m_el = 0;
            end
            m_ph = p; m_seen = 1;
        end else if (m_mode == M_TRACK) begin
            if (p != m_ph) begin
                m_ph = p; m_el = 0;
            end else if (tk) m_el = (m_el + 1 > 255) ? 255 : m_el + 1;
        end
        m_lamp = lamps;
        m_lv = 1;
    endfunction

    // Ticks until each direction's lamp changes, measured from the start of the phase
    function automatic exp_t expect_now();
        exp_t e;
        int b1, b2;
        b1 = (m_ph == 0) ? TG : (m_ph == 2) ? TG + TY : TY;
        b2 = (m_ph == 0) ? TG + TY : (m_ph == 2) ? TG : TY;
        e.ph = 2'(m_ph);
        e.pv = (m_mode == M_TRACK);
        e.f  = (m_mode == M_FAULT);
        e.c  = 3'(m_code);
        e.r1 = (m_cnt && b1 - 1 - m_el > 0) ? 8'(b1 - 1 - m_el) : 8'd0;
        e.r2 = (m_cnt && b2 - 1 - m_el > 0) ? 8'(b2 - 1 - m_el) : 8'd0;
        return e;
    endfunction

    task automatic cyc(input logic [5:0] l, input bit tk, input bit clr, input bit r);
        exp_t e;
        {bus.x1, bus.v1, bus.d1, bus.x2, bus.v2, bus.d2} = l;
        bus.tick = tk;
        bus.clr_fault = clr;
        rs = r;
        step(l, tk, clr, r);
        e = expect_now();
        @(posedge clk);
        #1;
        q.push_back(e);
    endtask

    task automatic hold(input int p, input int n, input int per);
        for (int i = 0; i < n; i++) begin
            cyc(pat[p], (tc % per) == 0, 1'b0, 1'b0);
            tc++;
        end
    endtask

    task automatic chk(input string nm, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d want %0d", nm, got, want);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_phase"}, int'(bus.phase), 0);
        chk({nm, "_valid"}, int'(bus.phase_valid), 0);
        chk({nm, "_remain1"}, int'(bus.remain1), 0);
        chk({nm, "_remain2"}, int'(bus.remain2), 0);
        chk({nm, "_fault"}, int'(bus.fault), 0);
        chk({nm, "_code"}, int'(bus.fault_code), 0);
    endtask

    // Monitor: every cycle the DUT presents outputs, compare against the oldest prediction
    initial begin
        exp_t e;
        logic [22:0] got, want;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                got  = {bus.phase, bus.phase_valid, bus.remain1, bus.remain2, bus.fault, bus.fault_code};
                want = {e.ph, e.pv, e.r1, e.r2, e.f, e.c};
                n_chk++;
                if (got === want) n_pass++;
                else $display("FAIL outputs @%0t: got %h want %h", $time, got, want);
            end
        end
    end

    initial begin
        pat[0] = 6'b100001;
        pat[1] = 6'b010001;
        pat[2] = 6'b001100;
        pat[3] = 6'b001010;
        rs = 1;
        bus.tick = 0;
        bus.clr_fault = 0;
        {bus.x1, bus.v1, bus.d1, bus.x2, bus.v2, bus.d2} = 6'b0;
        cyc(6'b0, 1'b0, 1'b0, 1'b1);
        cyc(6'b0, 1'b0, 1'b0, 1'b1);
        chk_zero("reset");
        // Nominal two rounds
        repeat (2) for (int p = 0; p < 4; p++) hold(p, (p % 2 == 1) ? TY : TG, 1);
        hold(0, 5, 1);
        chk("nominal_fault", int'(bus.fault), 0);
        chk("nominal_valid", int'(bus.phase_valid), 1);
        // Illegal both-green pulse
        cyc(6'b100100, 1'b1, 1'b0, 1'b0);
        hold(0, 1, 1);
        chk("illegal_fault", int'(bus.fault), 1);
        chk("illegal_code", int'(bus.fault_code), 1);
        chk("illegal_valid", int'(bus.phase_valid), 0);
        // Clear alone
        cyc(pat[0], 1'b1, 1'b1, 1'b0);
        chk("clr_fault", int'(bus.fault), 0);
        chk("clr_code", int'(bus.fault_code), 0);
        // Bad sequence P0->P2
        hold(0, 8, 1); hold(1, TY, 1); hold(2, TG, 1); hold(3, TY, 1); hold(0, TG, 1); hold(2, 2, 1);
        chk("badseq_code", int'(bus.fault_code), 2);
        // clr_fault with a simultaneous illegal vector
        cyc(6'b111111, 1'b1, 1'b0, 1'b0);
        cyc(pat[0], 1'b1, 1'b1, 1'b0);
        chk("clr_vs_illegal_fault", int'(bus.fault), 1);
        chk("clr_vs_illegal_code", int'(bus.fault_code), 1);
        cyc(pat[0], 1'b1, 1'b1, 1'b0);
        chk("clr2_fault", int'(bus.fault), 0);
        // Dwell short: P1 for 3 ticks
        hold(0, 10, 1); hold(1, 3, 1); hold(2, 2, 1);
        chk("short_code", int'(bus.fault_code), 3);
        // Dwell long: P0 held past its limit, later changes don't overwrite
        cyc(pat[2], 1'b1, 1'b1, 1'b0);
        hold(2, 4, 1); hold(3, TY, 1); hold(0, 20, 1); hold(1, 3, 1);
        chk("long_code", int'(bus.fault_code), 4);
        // Tick gating: one tick every 4 cycles, lamps stretched
        cyc(pat[1], 1'b1, 1'b1, 1'b0);
        tc = 0;
        hold(1, 8, 4); hold(2, 64, 4); hold(3, 24, 4); hold(0, 64, 4); hold(1, 24, 4); hold(2, 30, 4);
        chk("gated_fault", int'(bus.fault), 0);
        chk("gated_valid", int'(bus.phase_valid), 1);
        // Reset mid-P2
        cyc(pat[2], 1'b1, 1'b0, 1'b1);
        chk_zero("midreset");
        // Randomized phases with occasional bad timing, jumps, garbage vectors and clears
        begin
            int cp;
            cp = 2;
            for (int k = 0; k < 120; k++) begin
                int p, n, per;
                per = $urandom_range(1, 2);
                if (m_mode == M_FAULT && $urandom_range(0, 1) == 1) cyc(pat[cp], 1'b1, 1'b1, 1'b0);
                if ($urandom_range(0, 15) == 0) cyc(6'($urandom_range(0, 63)), 1'b1, 1'b0, 1'b0);
                p = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : (cp + 1) % 4;
                n = ((p % 2 == 1) ? TY : TG) + int'($urandom_range(0, 1));
                if ($urandom_range(0, 9) == 0) n = n + 2;
                if ($urandom_range(0, 9) == 0) n = n - 2;
                hold(p, n * per, per);
                cp = p;
            end
        end
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
